mem_bus_arbiter: RTL

//  Shares one physical-memory wishbone bus between the I-cache and D-cache miss ports (i_*, d_*).

---
 rtl/mem_bus_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one wishbone memory port between
// the I-cache and D-cache miss ports. The grant is held for a whole transfer and
// ends on ACK, RTY or requester abort. An IDLE bubble separates transfers.
// Optional watchdog, enabled by defining ARB_WATCHDOG_EN, retries a granted
// requester after TIMEOUT_CYCLES grant cycles with no ACK/RTY from memory.
module mem_bus_arbiter #(
   parameter int ADDR_W         = 12,
   parameter int DATA_W         = 128,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_stb,
   input  logic                i_we,
   input  logic [ADDR_W-1:0]   i_adr,
   input  logic [DATA_W/8-1:0] i_sel,
   input  logic [DATA_W-1:0]   i_dat_m,
   output logic                i_ack,
   output logic                i_rty,
   input  logic                d_stb,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_adr,
   input  logic [DATA_W/8-1:0] d_sel,
   input  logic [DATA_W-1:0]   d_dat_m,
   output logic                d_ack,
   output logic                d_rty,
   output logic                m_stb,
   output logic                m_cyc,
   output logic                m_we,
   output logic [ADDR_W-1:0]   m_adr,
   output logic [DATA_W/8-1:0] m_sel,
   output logic [DATA_W-1:0]   m_dat_m,
   input  logic                m_ack,
   input  logic                m_rty
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT_I = 2'd1,
      ST_GNT_D = 2'd2
   } state_t;

   // last_gnt encoding: 0 = I-cache was granted last, 1 = D-cache
   localparam logic LAST_I = 1'b0;
   localparam logic LAST_D = 1'b1;

   state_t state_r;
   state_t state_nxt_s;
   logic   last_gnt_r;
   logic   last_gnt_nxt_s;
   logic   timeout_s;

`ifdef ARB_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt_r;

   // Watchdog counter: zero while idle (so zero on grant entry), counts grant cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_r <= '0;
      end else if (state_r == ST_IDLE) begin
         wd_cnt_r <= '0;
      end else begin
         wd_cnt_r <= wd_cnt_r + WD_W'(1);
      end
   end

   // A real ACK/RTY in the limit cycle wins over the watchdog
   assign timeout_s = (state_r != ST_IDLE) && (wd_cnt_r == WD_W'(TIMEOUT_CYCLES))
                      && !m_ack && !m_rty;
`else
   // Without the watchdog the limit has no effect; keep it referenced
   logic [31:0] wd_limit_unused_s;
   assign wd_limit_unused_s = 32'(TIMEOUT_CYCLES);
   assign timeout_s         = 1'b0;
`endif

   // State and round-robin history registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         last_gnt_r <= LAST_I;
      end else begin
         state_r    <= state_nxt_s;
         last_gnt_r <= last_gnt_nxt_s;
      end
   end

   // Next-state selection and bus steering toward the granted requester
   always_comb begin
      state_nxt_s    = state_r;
      last_gnt_nxt_s = last_gnt_r;
      m_stb          = 1'b0;
      m_cyc          = 1'b0;
      m_we           = 1'b0;
      m_adr          = '0;
      m_sel          = '0;
      m_dat_m        = '0;
      i_ack          = 1'b0;
      i_rty          = 1'b0;
      d_ack          = 1'b0;
      d_rty          = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (i_stb && d_stb) begin
               // Tie: grant whichever port was not served last
               if (last_gnt_r == LAST_I) begin
                  state_nxt_s    = ST_GNT_D;
                  last_gnt_nxt_s = LAST_D;
               end else begin
                  state_nxt_s    = ST_GNT_I;
                  last_gnt_nxt_s = LAST_I;
               end
            end else if (i_stb) begin
               state_nxt_s    = ST_GNT_I;
               last_gnt_nxt_s = LAST_I;
            end else if (d_stb) begin
               state_nxt_s    = ST_GNT_D;
               last_gnt_nxt_s = LAST_D;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end

         ST_GNT_I: begin
            m_stb   = i_stb && !timeout_s;
            m_cyc   = i_stb && !timeout_s;
            m_we    = i_we;
            m_adr   = i_adr;
            m_sel   = i_sel;
            m_dat_m = i_dat_m;
            i_ack   = m_ack;
            i_rty   = m_rty || timeout_s;
            if (m_ack || m_rty || !i_stb || timeout_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_GNT_I;
            end
         end

         ST_GNT_D: begin
            m_stb   = d_stb && !timeout_s;
            m_cyc   = d_stb && !timeout_s;
            m_we    = d_we;
            m_adr   = d_adr;
            m_sel   = d_sel;
            m_dat_m = d_dat_m;
            d_ack   = m_ack;
            d_rty   = m_rty || timeout_s;
            if (m_ack || m_rty || !d_stb || timeout_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_GNT_D;
            end
         end

         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

endmodule
